hsid_sq_df_acc_ctrl: RTL and testbench
======================================

# hsid_sq_df_acc_ctrl

Sequencer for the squared-difference accumulator (`hsid_sq_df_acc`). On a start pulse it streams every band of one test pixel against every pixel of the spectral library, one band per cycle, with no gaps. It tags each library pixel with its index and collects the per-pixel distances returned by the datapath. It reports the library index with the minimum accumulated distance. It sits between the pixel/library memories and the datapath, under the top-level HSID controller.

## Interface
Parameters:
- `DATA_WIDTH`, `HSID_DATA_WIDTH`, band sample width
- `DATA_WIDTH_ACC`, `HSID_DATA_WIDTH_ACC`, accumulator/distance width
- `HSP_BANDS_WIDTH`, `HSID_HSP_BANDS_WIDTH`, band count/index width
- `HSP_LIBRARY_WIDTH`, `HSID_HSP_LIBRARY_WIDTH`, library count/index width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a search; sampled only in IDLE
- `hsp_bands` in HSP_BANDS_WIDTH: bands per pixel; latched at start
- `hsp_library_size` in HSP_LIBRARY_WIDTH: library pixels; latched at start
- `test_rd_en` out 1: test-pixel memory read strobe
- `test_rd_addr` out HSP_BANDS_WIDTH: band index
- `test_rd_data` in DATA_WIDTH: valid exactly 1 cycle after `test_rd_en`
- `lib_rd_en` out 1: library memory read strobe
- `lib_rd_addr` out HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH: {lib index, band index}
- `lib_rd_data` in DATA_WIDTH: valid exactly 1 cycle after `lib_rd_en`
- `initial_acc_en` out 1, `initial_acc` out DATA_WIDTH_ACC: initial value for the datapath accumulator
- `data_in_valid` out 1, `data_in_a` out DATA_WIDTH, `data_in_b` out DATA_WIDTH, `data_in_last` out 1, `data_in_ref` out HSP_LIBRARY_WIDTH: to the datapath
- `acc_valid` in 1, `acc_value` in DATA_WIDTH_ACC, `acc_last` in 1, `acc_ref` in HSP_LIBRARY_WIDTH: from the datapath
- `busy` out 1: high from the cycle after an accepted start until `done`
- `done` out 1: one-cycle pulse when results are final
- `min_ref` out HSP_LIBRARY_WIDTH, `min_value` out DATA_WIDTH_ACC: search result

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE → RUN when `start` is high. Config is latched, counters are cleared, and the running minimum is set to all-ones with ref 0.
- If a latched size is 0, the FSM goes IDLE → DONE instead. No reads are issued, `min_value` = all-ones and `min_ref` = 0.
- RUN: `test_rd_en` = `lib_rd_en` = 1 every cycle.
  - Band counter wraps at hsp_bands-1 and increments the lib counter at each wrap.
  - After band hsp_bands-1 of lib hsp_library_size-1, the FSM goes to DRAIN.
- Issue tags (band==0, band==last, lib index) are delayed 1 cycle alongside the read data.
- `data_in_valid` is the 1-cycle-delayed read strobe.
- `data_in_a`/`data_in_b` come directly from `test_rd_data`/`lib_rd_data`.
- `data_in_last` = delayed (band==last); `data_in_ref` = delayed lib index.
- `initial_acc_en` = delayed (band==0) AND valid, with `initial_acc` = 0. This restarts accumulation for every library pixel.
- Result collection runs in RUN and DRAIN. On each `acc_valid & acc_last`:
  - the result counter increments;
  - if `acc_value` < `min_value` (strict), both `min_value` and `min_ref` are updated from `acc_value`/`acc_ref`.
  - A tie keeps the lower ref, because refs return in order.
- DRAIN → DONE when the result counter reaches hsp_library_size (the final update is included).
- DONE: `done` = 1 for 1 cycle, then IDLE.
- `min_ref`/`min_value` hold until the next accepted start.
- `start` outside IDLE is ignored.
- `acc_valid` without `acc_last` is ignored.

## Timing
- Reset values: all outputs 0 except `min_value` = all-ones. The FSM resets to IDLE.
- Reset mid-search aborts immediately. No `done` is issued.
- Start sampled at edge N:
  - first read at cycle N+1;
  - first `data_in_valid` at N+2;
  - reads continue for B·L consecutive cycles.
- The controller does not assume a fixed datapath latency; it counts `acc_last` pulses. With the 3-stage datapath, `done` = last `data_in_last` + 4 cycles.
- Back-to-back library pixels have zero bubble. `initial_acc_en` coincides with `data_in_valid` of band 0.
- hsp_bands = 1: `initial_acc_en` and `data_in_last` are asserted together every cycle.

## Structure
- State enum `hsid_sq_df_acc_ctrl_state_t` and the all-ones `HSID_ACC_MAX` constant go in `hsid_pkg`.
- The address generator (band/lib counters with wrap and end flag) is a natural sub-module: `hsid_band_lib_cnt`.
- The datapath is instantiated by the parent, not inside this block.

## Test plan
- B=4, L=3, test=[1,2,3,4], lib0=[1,2,3,4], lib1=[0,0,0,0], lib2=[2,2,2,2] → distances 0, 30, 6; `min_ref`=0, `min_value`=0; `done` at last `data_in_last`+4.
- B=2, L=3, lib distances 9, 4, 4 → `min_ref`=1 (tie keeps first), `min_value`=4.
- B=1, L=5 → `initial_acc_en` and `data_in_last` high on 5 consecutive valid cycles; refs 0..4 in order.
- L=0 (or B=0) → `done` 1 cycle after start, no read strobes, `min_value`=all-ones, `min_ref`=0.
- `start` pulsed while busy, then `rst_n` low mid-RUN → second start ignored; after reset all outputs are at reset values and no `done` occurs; a new search then completes correctly.

Source files
------------

// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSID squared-difference accumulator
// sequencer: default widths, the controller state encoding and the
// all-ones distance used as the "no minimum yet" value.
package hsid_pkg;

    localparam int HSID_DATA_WIDTH        = 16;
    localparam int HSID_DATA_WIDTH_ACC    = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;

    // Largest representable distance; seeds the running minimum.
    localparam logic [HSID_DATA_WIDTH_ACC-1:0] HSID_ACC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } hsid_sq_df_acc_ctrl_state_t;

endpackage

// File: rtl/hsid_sq_df_acc_ctrl_if.sv
// Bus bundle between the sequencer, the test/library memories and the
// squared-difference datapath.
//
// Stream semantics: every transfer on this bundle is valid-only. A strobe
// (test_rd_en, lib_rd_en, data_in_valid, acc_valid, initial_acc_en) marks a
// transfer in that cycle and there is no ready/backpressure: the receiver
// must accept every strobed beat. Memory read data is valid exactly one
// cycle after its read strobe.
interface hsid_sq_df_acc_ctrl_if
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
    parameter int DATA_WIDTH_ACC    = HSID_DATA_WIDTH_ACC,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) ();

    // Memory side
    logic                                       test_rd_en;
    logic [HSP_BANDS_WIDTH-1:0]                 test_rd_addr;
    logic [DATA_WIDTH-1:0]                      test_rd_data;
    logic                                       lib_rd_en;
    logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-1:0] lib_rd_addr;
    logic [DATA_WIDTH-1:0]                      lib_rd_data;

    // Datapath input side
    logic                                       initial_acc_en;
    logic [DATA_WIDTH_ACC-1:0]                  initial_acc;
    logic                                       data_in_valid;
    logic [DATA_WIDTH-1:0]                      data_in_a;
    logic [DATA_WIDTH-1:0]                      data_in_b;
    logic                                       data_in_last;
    logic [HSP_LIBRARY_WIDTH-1:0]               data_in_ref;

    // Datapath result side
    logic                                       acc_valid;
    logic [DATA_WIDTH_ACC-1:0]                  acc_value;
    logic                                       acc_last;
    logic [HSP_LIBRARY_WIDTH-1:0]               acc_ref;

    // Sequencer view
    modport master (
        output test_rd_en, test_rd_addr,
        input  test_rd_data,
        output lib_rd_en, lib_rd_addr,
        input  lib_rd_data,
        output initial_acc_en, initial_acc,
        output data_in_valid, data_in_a, data_in_b, data_in_last, data_in_ref,
        input  acc_valid, acc_value, acc_last, acc_ref
    );

    // Memories + datapath view
    modport slave (
        input  test_rd_en, test_rd_addr,
        output test_rd_data,
        input  lib_rd_en, lib_rd_addr,
        output lib_rd_data,
        input  initial_acc_en, initial_acc,
        input  data_in_valid, data_in_a, data_in_b, data_in_last, data_in_ref,
        output acc_valid, acc_value, acc_last, acc_ref
    );

endinterface

// File: rtl/hsid_band_lib_cnt.sv
// Address generator: band counter nested inside a library-pixel counter.
// The band counter wraps at bands-1 and bumps the library counter; o_end
// flags the final band of the final library pixel. Both counters return to
// zero after the final beat so the addresses idle at 0.
module hsid_band_lib_cnt
    import hsid_pkg::*;
#(
    parameter int BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic [BANDS_WIDTH-1:0]   i_bands,
    input  logic [LIBRARY_WIDTH-1:0] i_lib_size,
    output logic [BANDS_WIDTH-1:0]   o_band,
    output logic [LIBRARY_WIDTH-1:0] o_lib,
    output logic                     o_band_first,
    output logic                     o_band_last,
    output logic                     o_end
);

    logic [BANDS_WIDTH-1:0]   r_band;
    logic [LIBRARY_WIDTH-1:0] r_lib;
    logic [BANDS_WIDTH-1:0]   w_band_max;
    logic [LIBRARY_WIDTH-1:0] w_lib_max;
    logic                     w_band_last;
    logic                     w_lib_last;

    assign w_band_max  = i_bands - 1'b1;
    assign w_lib_max   = i_lib_size - 1'b1;
    assign w_band_last = (r_band == w_band_max);
    assign w_lib_last  = (r_lib == w_lib_max);

    // Advance band, carry into library index on band wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_band <= '0;
            r_lib  <= '0;
        end else if (i_clear) begin
            r_band <= '0;
            r_lib  <= '0;
        end else if (i_en) begin
            if (w_band_last) begin
                r_band <= '0;
                r_lib  <= w_lib_last ? '0 : r_lib + 1'b1;
            end else begin
                r_band <= r_band + 1'b1;
            end
        end
    end

    assign o_band       = r_band;
    assign o_lib        = r_lib;
    assign o_band_first = (r_band == '0);
    assign o_band_last  = w_band_last;
    assign o_end        = w_band_last && w_lib_last;

endmodule

// File: rtl/hsid_sq_df_acc_ctrl.sv
// Sequencer for the squared-difference accumulator. Streams every band of
// the test pixel against every library pixel (one band per cycle, no gaps),
// tags each beat with its library index, then tracks the library index with
// the smallest returned distance. Completion is detected by counting
// per-pixel results, so the datapath latency is not assumed.
module hsid_sq_df_acc_ctrl
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
    parameter int DATA_WIDTH_ACC    = HSID_DATA_WIDTH_ACC,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    hsid_sq_df_acc_ctrl_if.master        bus,
    output logic                         busy,
    output logic                         done,
    output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
    output logic [DATA_WIDTH_ACC-1:0]    min_value,
    output hsid_sq_df_acc_ctrl_state_t   dbg_state
);

    hsid_sq_df_acc_ctrl_state_t r_state;
    hsid_sq_df_acc_ctrl_state_t w_state_nxt;

    // Latched configuration and result tracking
    logic [HSP_BANDS_WIDTH-1:0]   r_bands;
    logic [HSP_LIBRARY_WIDTH-1:0] r_lib_size;
    logic [HSP_LIBRARY_WIDTH-1:0] r_res_cnt;
    logic [DATA_WIDTH_ACC-1:0]    r_min_value;
    logic [HSP_LIBRARY_WIDTH-1:0] r_min_ref;

    // Issue tags delayed to line up with the read data
    logic                         r_dly_valid;
    logic                         r_dly_first;
    logic                         r_dly_last;
    logic [HSP_LIBRARY_WIDTH-1:0] r_dly_ref;

    // Address generator
    logic [HSP_BANDS_WIDTH-1:0]   w_band;
    logic [HSP_LIBRARY_WIDTH-1:0] w_lib;
    logic                         w_band_first;
    logic                         w_band_last;
    logic                         w_end;

    // Control
    logic                         w_accept;
    logic                         w_cfg_empty;
    logic                         w_rd_en;
    logic                         w_busy;
    logic                         w_done;
    logic                         w_collect;
    logic                         w_res_hit;
    logic                         w_res_done;
    logic [HSP_LIBRARY_WIDTH-1:0] w_res_next;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_cfg_empty = (hsp_bands == '0) || (hsp_library_size == '0);
    assign w_collect   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_res_hit   = w_collect && bus.acc_valid && bus.acc_last;
    assign w_res_next  = r_res_cnt + 1'b1;
    // The final result is counted in the same cycle it arrives.
    assign w_res_done  = (r_res_cnt == r_lib_size) ||
                         (w_res_hit && (w_res_next == r_lib_size));

    hsid_band_lib_cnt #(
        .BANDS_WIDTH   (HSP_BANDS_WIDTH),
        .LIBRARY_WIDTH (HSP_LIBRARY_WIDTH)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_en         (w_rd_en),
        .i_bands      (r_bands),
        .i_lib_size   (r_lib_size),
        .o_band       (w_band),
        .o_lib        (w_lib),
        .o_band_first (w_band_first),
        .o_band_last  (w_band_last),
        .o_end        (w_end)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (w_end) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_res_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Config latch and running minimum over per-pixel results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bands     <= '0;
            r_lib_size  <= '0;
            r_res_cnt   <= '0;
            r_min_value <= '1;
            r_min_ref   <= '0;
        end else if (w_accept) begin
            r_bands     <= hsp_bands;
            r_lib_size  <= hsp_library_size;
            r_res_cnt   <= '0;
            r_min_value <= '1;
            r_min_ref   <= '0;
        end else if (w_res_hit) begin
            r_res_cnt <= w_res_next;
            // Strict compare: refs return in order, so a tie keeps the lower ref.
            if (bus.acc_value < r_min_value) begin
                r_min_value <= bus.acc_value;
                r_min_ref   <= bus.acc_ref;
            end
        end
    end

    // Delay issue tags by one cycle to match memory read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_valid <= 1'b0;
            r_dly_first <= 1'b0;
            r_dly_last  <= 1'b0;
            r_dly_ref   <= '0;
        end else begin
            r_dly_valid <= w_rd_en;
            if (w_rd_en) begin
                r_dly_first <= w_band_first;
                r_dly_last  <= w_band_last;
                r_dly_ref   <= w_lib;
            end
        end
    end

    assign bus.test_rd_en     = w_rd_en;
    assign bus.test_rd_addr   = w_band;
    assign bus.lib_rd_en      = w_rd_en;
    assign bus.lib_rd_addr    = {w_lib, w_band};

    // Accumulation restarts at zero on band 0 of every library pixel.
    assign bus.initial_acc_en = r_dly_valid & r_dly_first;
    assign bus.initial_acc    = '0;
    assign bus.data_in_valid  = r_dly_valid;
    assign bus.data_in_a      = r_dly_valid ? bus.test_rd_data : '0;
    assign bus.data_in_b      = r_dly_valid ? bus.lib_rd_data : '0;
    assign bus.data_in_last   = r_dly_valid & r_dly_last;
    assign bus.data_in_ref    = r_dly_ref;

    assign busy      = w_busy;
    assign done      = w_done;
    assign min_ref   = r_min_ref;
    assign min_value = r_min_value;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hsid_sq_df_acc_ctrl.sv
// Directed bench for hsid_sq_df_acc_ctrl: memory models, a 3-stage
// squared-difference datapath model, a negedge monitor and a linear list of
// directed searches with hand-computed distances and minima.
module tb_hsid_sq_df_acc_ctrl;
    import hsid_pkg::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int BW = 4;
    localparam int LW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [BW-1:0] hsp_bands = '0;
    logic [LW-1:0] hsp_library_size = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] min_ref;
    logic [AW-1:0] min_value;
    hsid_sq_df_acc_ctrl_state_t dbg_state;

    hsid_sq_df_acc_ctrl_if #(
        .DATA_WIDTH(DW), .DATA_WIDTH_ACC(AW),
        .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)
    ) bus ();

    hsid_sq_df_acc_ctrl #(
        .DATA_WIDTH(DW), .DATA_WIDTH_ACC(AW),
        .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .hsp_bands        (hsp_bands),
        .hsp_library_size (hsp_library_size),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .min_ref          (min_ref),
        .min_value        (min_value),
        .dbg_state        (dbg_state)
    );

    // ---------------- memories (1-cycle read) ----------------
    logic [DW-1:0] test_mem [0:(1<<BW)-1];
    logic [DW-1:0] lib_mem  [0:(1<<(BW+LW))-1];
    logic [DW-1:0] test_q = '0;
    logic [DW-1:0] lib_q = '0;

    always @(posedge clk) begin
        if (bus.test_rd_en) test_q <= test_mem[bus.test_rd_addr];
        if (bus.lib_rd_en)  lib_q  <= lib_mem[bus.lib_rd_addr];
    end
    assign bus.test_rd_data = test_q;
    assign bus.lib_rd_data  = lib_q;

    // ---------------- 3-stage datapath model ----------------
    function automatic logic [AW-1:0] sq_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [AW-1:0] d;
        d = (a > b) ? AW'(a - b) : AW'(b - a);
        return d * d;
    endfunction

    logic          s1_v, s1_l, s1_i;
    logic [DW-1:0] s1_a, s1_b;
    logic [LW-1:0] s1_r;
    logic [AW-1:0] s1_init;
    logic          s2_v, s2_l, s2_i;
    logic [AW-1:0] s2_sq, s2_init;
    logic [LW-1:0] s2_r;
    logic          dp_v, dp_l;
    logic [AW-1:0] dp_acc;
    logic [LW-1:0] dp_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 0; s1_l <= 0; s1_i <= 0; s1_a <= '0; s1_b <= '0; s1_r <= '0; s1_init <= '0;
            s2_v <= 0; s2_l <= 0; s2_i <= 0; s2_sq <= '0; s2_init <= '0; s2_r <= '0;
            dp_v <= 0; dp_l <= 0; dp_acc <= '0; dp_r <= '0;
        end else begin
            s1_v <= bus.data_in_valid; s1_l <= bus.data_in_last; s1_i <= bus.initial_acc_en;
            s1_a <= bus.data_in_a; s1_b <= bus.data_in_b; s1_r <= bus.data_in_ref;
            s1_init <= bus.initial_acc;
            s2_v <= s1_v; s2_l <= s1_l; s2_i <= s1_i; s2_sq <= sq_diff(s1_a, s1_b);
            s2_init <= s1_init; s2_r <= s1_r;
            dp_v <= s2_v; dp_l <= s2_v & s2_l; dp_r <= s2_r;
            if (s2_v) dp_acc <= (s2_i ? s2_init : dp_acc) + s2_sq;
        end
    end
    assign bus.acc_valid = dp_v;
    assign bus.acc_last  = dp_l;
    assign bus.acc_value = dp_acc;
    assign bus.acc_ref   = dp_r;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, lib_rd_cnt = 0, ia_cnt = 0, last_cnt = 0, pair_diff = 0, done_cnt = 0;
    int rd_rise_cyc = -1, vld_rise_cyc = -1, last_cyc = -1, done_cyc = -1;
    logic prev_rd = 1'b0, prev_vld = 1'b0;
    logic [AW-1:0] dist_q[$];
    logic [LW-1:0] ref_q[$];

    always @(negedge clk) begin
        prev_rd  <= bus.test_rd_en;
        prev_vld <= bus.data_in_valid;
        if (bus.test_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.lib_rd_en) lib_rd_cnt <= lib_rd_cnt + 1;
        if (bus.test_rd_en && !prev_rd) rd_rise_cyc <= cyc;
        if (bus.data_in_valid && !prev_vld) vld_rise_cyc <= cyc;
        if (bus.data_in_valid) begin
            if (bus.initial_acc_en != bus.data_in_last) pair_diff <= pair_diff + 1;
            if (bus.initial_acc_en) ia_cnt <= ia_cnt + 1;
            if (bus.data_in_last) begin
                last_cnt <= last_cnt + 1;
                last_cyc <= cyc;
                ref_q.push_back(bus.data_in_ref);
            end
        end
        if (bus.acc_valid && bus.acc_last) dist_q.push_back(bus.acc_value);
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // ---------------- scoreboard / checking ----------------
    int total = 0;
    int bad = 0;
    logic [AW-1:0] exp_q[$];
    int start_cyc = 0;
    int b_rd, b_lib, b_ia, b_last, b_pair, b_done, b_dist, b_ref;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] dist_at(input int idx);
        if (idx < dist_q.size()) return dist_q[idx];
        return 'x;
    endfunction

    function automatic logic [LW-1:0] ref_at(input int idx);
        if (idx < ref_q.size()) return ref_q[idx];
        return 'x;
    endfunction

    task automatic snap();
        b_rd = rd_cnt; b_lib = lib_rd_cnt; b_ia = ia_cnt; b_last = last_cnt;
        b_pair = pair_diff; b_done = done_cnt; b_dist = dist_q.size(); b_ref = ref_q.size();
    endtask

    task automatic set_lib(input int lib, input int band, input int val);
        lib_mem[(lib << BW) + band] = DW'(val);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_search(input int b, input int l);
        @(negedge clk);
        hsp_bands = BW'(b);
        hsp_library_size = LW'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_dists(input string tag, input int n);
        check({tag, "_n_results"}, 64'(dist_q.size() - b_dist), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_dist%0d", tag, i), 64'(dist_at(b_dist + i)), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_test_rd_en"}, 64'(bus.test_rd_en), 64'd0);
        check({tag, "_lib_rd_en"}, 64'(bus.lib_rd_en), 64'd0);
        check({tag, "_lib_rd_addr"}, 64'(bus.lib_rd_addr), 64'd0);
        check({tag, "_data_in_valid"}, 64'(bus.data_in_valid), 64'd0);
        check({tag, "_data_in_a"}, 64'(bus.data_in_a), 64'd0);
        check({tag, "_initial_acc_en"}, 64'(bus.initial_acc_en), 64'd0);
        check({tag, "_data_in_last"}, 64'(bus.data_in_last), 64'd0);
        check({tag, "_data_in_ref"}, 64'(bus.data_in_ref), 64'd0);
        check({tag, "_min_ref"}, 64'(min_ref), 64'd0);
        check({tag, "_min_value"}, 64'(min_value), 64'(HSID_ACC_MAX));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < (1 << BW); i++) test_mem[i] = '0;
        for (int i = 0; i < (1 << (BW + LW)); i++) lib_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: B=4 L=3 -> distances 0, 30, 6; min ref 0 value 0
        test_mem[0] = 1; test_mem[1] = 2; test_mem[2] = 3; test_mem[3] = 4;
        set_lib(0, 0, 1); set_lib(0, 1, 2); set_lib(0, 2, 3); set_lib(0, 3, 4);
        set_lib(1, 0, 0); set_lib(1, 1, 0); set_lib(1, 2, 0); set_lib(1, 3, 0);
        set_lib(2, 0, 2); set_lib(2, 1, 2); set_lib(2, 2, 2); set_lib(2, 3, 2);
        exp_q.push_back(0); exp_q.push_back(30); exp_q.push_back(6);
        snap();
        start_search(4, 3);
        check("t1_busy_running", 64'(busy), 64'd1);
        wait_done("t1", 60);
        check("t1_first_read_cyc", 64'(rd_rise_cyc), 64'(start_cyc));
        check("t1_first_valid_cyc", 64'(vld_rise_cyc), 64'(start_cyc + 1));
        check("t1_test_reads", 64'(rd_cnt - b_rd), 64'd12);
        check("t1_lib_reads", 64'(lib_rd_cnt - b_lib), 64'd12);
        check("t1_init_acc_en", 64'(ia_cnt - b_ia), 64'd3);
        check("t1_last_count", 64'(last_cnt - b_last), 64'd3);
        check("t1_done_latency", 64'(done_cyc), 64'(last_cyc + 4));
        check("t1_done_count", 64'(done_cnt - b_done), 64'd1);
        check_dists("t1", 3);
        check("t1_min_ref", 64'(min_ref), 64'd0);
        check("t1_min_value", 64'(min_value), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_state_after", 64'(dbg_state), 64'(ST_IDLE));

        // T2: B=2 L=3 -> distances 9, 4, 4; tie keeps ref 1
        test_mem[0] = 0; test_mem[1] = 0;
        set_lib(0, 0, 3); set_lib(0, 1, 0);
        set_lib(1, 0, 2); set_lib(1, 1, 0);
        set_lib(2, 0, 0); set_lib(2, 1, 2);
        exp_q.push_back(9); exp_q.push_back(4); exp_q.push_back(4);
        snap();
        start_search(2, 3);
        wait_done("t2", 40);
        check("t2_test_reads", 64'(rd_cnt - b_rd), 64'd6);
        check("t2_done_latency", 64'(done_cyc), 64'(last_cyc + 4));
        check_dists("t2", 3);
        check("t2_min_ref", 64'(min_ref), 64'd1);
        check("t2_min_value", 64'(min_value), 64'd4);
        repeat (3) @(negedge clk);
        check("t2_min_ref_held", 64'(min_ref), 64'd1);
        check("t2_min_value_held", 64'(min_value), 64'd4);

        // T3: B=1 L=5, test=10, lib k = k -> distances 100,81,64,49,36
        test_mem[0] = 10;
        for (int k = 0; k < 5; k++) begin
            set_lib(k, 0, k);
            exp_q.push_back(AW'((10 - k) * (10 - k)));
        end
        snap();
        start_search(1, 5);
        wait_done("t3", 40);
        check("t3_init_acc_en", 64'(ia_cnt - b_ia), 64'd5);
        check("t3_last_count", 64'(last_cnt - b_last), 64'd5);
        check("t3_init_vs_last", 64'(pair_diff - b_pair), 64'd0);
        check("t3_consecutive", 64'(last_cyc - vld_rise_cyc), 64'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_ref%0d", k), 64'(ref_at(b_ref + k)), 64'(k));
        end
        check_dists("t3", 5);
        check("t3_min_ref", 64'(min_ref), 64'd4);
        check("t3_min_value", 64'(min_value), 64'd36);

        // T4: empty configurations finish with no reads
        snap();
        start_search(3, 0);
        wait_done("t4a", 4);
        check("t4a_done_cyc", 64'(done_cyc), 64'(start_cyc));
        check("t4a_reads", 64'(rd_cnt - b_rd), 64'd0);
        check("t4a_lib_reads", 64'(lib_rd_cnt - b_lib), 64'd0);
        check("t4a_min_value", 64'(min_value), 64'(HSID_ACC_MAX));
        check("t4a_min_ref", 64'(min_ref), 64'd0);
        repeat (3) @(negedge clk);
        check("t4a_done_once", 64'(done_cnt - b_done), 64'd1);
        snap();
        start_search(0, 2);
        wait_done("t4b", 4);
        check("t4b_done_cyc", 64'(done_cyc), 64'(start_cyc));
        check("t4b_reads", 64'(rd_cnt - b_rd), 64'd0);
        check("t4b_min_value", 64'(min_value), 64'(HSID_ACC_MAX));

        // T5a: start pulsed while busy is ignored; config stays latched
        test_mem[0] = 5; test_mem[1] = 1;
        set_lib(0, 0, 1); set_lib(0, 1, 1);
        set_lib(1, 0, 5); set_lib(1, 1, 4);
        exp_q.push_back(16); exp_q.push_back(9);
        snap();
        start_search(2, 2);
        @(negedge clk);
        hsp_bands = 3; hsp_library_size = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5a", 40);
        check("t5a_reads", 64'(rd_cnt - b_rd), 64'd4);
        check("t5a_done_count", 64'(done_cnt - b_done), 64'd1);
        check_dists("t5a", 2);
        check("t5a_min_ref", 64'(min_ref), 64'd1);
        check("t5a_min_value", 64'(min_value), 64'd9);

        // T5b: reset in the middle of RUN aborts with no done
        snap();
        start_search(3, 4);
        repeat (4) @(negedge clk);
        check("t5b_busy_mid", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5b_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5b_no_done", 64'(done_cnt - b_done), 64'd0);
        check("t5b_state", 64'(dbg_state), 64'(ST_IDLE));

        // T5c: a new search completes after the abort; distances 9, 4, 0
        test_mem[0] = 7;
        set_lib(0, 0, 4); set_lib(1, 0, 9); set_lib(2, 0, 7);
        exp_q.push_back(9); exp_q.push_back(4); exp_q.push_back(0);
        snap();
        start_search(1, 3);
        wait_done("t5c", 40);
        check("t5c_reads", 64'(rd_cnt - b_rd), 64'd3);
        check("t5c_done_latency", 64'(done_cyc), 64'(last_cyc + 4));
        check_dists("t5c", 3);
        check("t5c_min_ref", 64'(min_ref), 64'd2);
        check("t5c_min_value", 64'(min_value), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
